fir_stim_source: RTL and testbench

Sample source for the 128-tap FIR filter block. Generates a 16-bit signed stimulus stream (impulse, step, square, sine) and drives the filter's `input_sig`/`ready` pair. The filter captures one sample per 128 `ready` cycles, so this block holds each sample for a full frame and deasserts `ready` only on frame boundaries. This keeps the filter, which has no reset, frame-aligned. Used on the bench and as an on-chip self-test source ahead of the filter.

---
 rtl/fir_stim_pkg.sv | 32 +++
 rtl/sine_lut_q15.sv | 93 +++++++++
 rtl/fir_stim_source.sv | 186 ++++++++++++++++++
 tb/tb_fir_stim_source.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_stim_pkg.sv
// fir_stim_pkg: shared constants and types for the FIR stimulus source.
// Optional feature macro used by the design: FIR_STIM_SINE_EN (sine mode + LUT).
package fir_stim_pkg;

   // Default sample width and frame length (frame length equals the filter tap count)
   localparam int WIDTH_DEF     = 16;
   localparam int FRAME_LEN_DEF = 128;
   localparam int PHASE_W_DEF   = 16;
   localparam int FLUSH_LEN_DEF = 128;

   // Amplitude is an unsigned Q15 magnitude; burst length counter width
   localparam int AMP_W = 15;
   localparam int NUM_W = 16;

   // Quarter-wave sine table: 65 entries covering 0..pi/2 inclusive
   localparam int LUT_DEPTH  = 65;
   localparam int LUT_ADDR_W = 7;

   typedef enum logic [1:0] {
      MODE_IMPULSE = 2'd0,
      MODE_STEP    = 2'd1,
      MODE_SINE    = 2'd2,
      MODE_SQUARE  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/sine_lut_q15.sv
// sine_lut_q15: quadrant folding plus 65-entry quarter-wave Q15 sine ROM.
// Purely combinational; only instantiated when FIR_STIM_SINE_EN is defined.
module sine_lut_q15
   import fir_stim_pkg::*;
(
   input  logic [1:0]  i_quadrant,
   input  logic [5:0]  i_index,
   output logic [14:0] o_mag,
   output logic        o_neg
);

   logic [LUT_ADDR_W-1:0] w_addr;

   // Odd quadrants walk the quarter wave backwards; upper half-cycle is negative
   assign w_addr = i_quadrant[0] ? (LUT_ADDR_W'(LUT_DEPTH - 1) - {1'b0, i_index})
                                 : {1'b0, i_index};
   assign o_neg  = i_quadrant[1];

   // ROM: round(32767 * sin(k * pi / 128)) for k = 0..64
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves o_mag unassigned (no latch).
      o_mag = '0;
      case (w_addr)
         7'd0:  o_mag = 15'd0;
         7'd1:  o_mag = 15'd804;
         7'd2:  o_mag = 15'd1608;
         7'd3:  o_mag = 15'd2410;
         7'd4:  o_mag = 15'd3212;
         7'd5:  o_mag = 15'd4011;
         7'd6:  o_mag = 15'd4808;
         7'd7:  o_mag = 15'd5602;
         7'd8:  o_mag = 15'd6393;
         7'd9:  o_mag = 15'd7179;
         7'd10: o_mag = 15'd7962;
         7'd11: o_mag = 15'd8739;
         7'd12: o_mag = 15'd9512;
         7'd13: o_mag = 15'd10278;
         7'd14: o_mag = 15'd11039;
         7'd15: o_mag = 15'd11793;
         7'd16: o_mag = 15'd12539;
         7'd17: o_mag = 15'd13279;
         7'd18: o_mag = 15'd14010;
         7'd19: o_mag = 15'd14732;
         7'd20: o_mag = 15'd15446;
         7'd21: o_mag = 15'd16151;
         7'd22: o_mag = 15'd16846;
         7'd23: o_mag = 15'd17530;
         7'd24: o_mag = 15'd18204;
         7'd25: o_mag = 15'd18868;
         7'd26: o_mag = 15'd19519;
         7'd27: o_mag = 15'd20159;
         7'd28: o_mag = 15'd20787;
         7'd29: o_mag = 15'd21403;
         7'd30: o_mag = 15'd22005;
         7'd31: o_mag = 15'd22594;
         7'd32: o_mag = 15'd23170;
         7'd33: o_mag = 15'd23731;
         7'd34: o_mag = 15'd24279;
         7'd35: o_mag = 15'd24811;
         7'd36: o_mag = 15'd25329;
         7'd37: o_mag = 15'd25832;
         7'd38: o_mag = 15'd26319;
         7'd39: o_mag = 15'd26790;
         7'd40: o_mag = 15'd27245;
         7'd41: o_mag = 15'd27683;
         7'd42: o_mag = 15'd28105;
         7'd43: o_mag = 15'd28510;
         7'd44: o_mag = 15'd28898;
         7'd45: o_mag = 15'd29268;
         7'd46: o_mag = 15'd29621;
         7'd47: o_mag = 15'd29956;
         7'd48: o_mag = 15'd30273;
         7'd49: o_mag = 15'd30571;
         7'd50: o_mag = 15'd30852;
         7'd51: o_mag = 15'd31113;
         7'd52: o_mag = 15'd31356;
         7'd53: o_mag = 15'd31580;
         7'd54: o_mag = 15'd31785;
         7'd55: o_mag = 15'd31971;
         7'd56: o_mag = 15'd32137;
         7'd57: o_mag = 15'd32285;
         7'd58: o_mag = 15'd32412;
         7'd59: o_mag = 15'd32521;
         7'd60: o_mag = 15'd32609;
         7'd61: o_mag = 15'd32678;
         7'd62: o_mag = 15'd32728;
         7'd63: o_mag = 15'd32757;
         7'd64: o_mag = 15'd32767;
         default: o_mag = '0;
      endcase
   end

endmodule

// File: rtl/fir_stim_source.sv
// fir_stim_source: frame-aligned stimulus source (impulse/step/sine/square) for
// the 128-tap FIR filter. Each sample is held for FRAME_LEN ready cycles and
// ready only drops on a frame boundary, keeping the reset-less filter aligned.
// Optional feature macro: FIR_STIM_SINE_EN (without it, sine mode emits zeros).
module fir_stim_source
   import fir_stim_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int PHASE_W   = PHASE_W_DEF,
   parameter int FLUSH_LEN = FLUSH_LEN_DEF
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic [1:0]              mode,
   input  logic [AMP_W-1:0]        amplitude,
   input  logic [PHASE_W-1:0]      phase_inc,
   input  logic [NUM_W-1:0]        num_samples,
   output logic                    ready,
   output logic signed [WIDTH-1:0] sig_out,
   output logic                    sample_stb,
   output logic                    busy,
   output logic                    done
);

   localparam int CNT_W = $clog2(FRAME_LEN);
   localparam int FL_W  = (FLUSH_LEN < 2) ? 1 : $clog2(FLUSH_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   state_e               r_state;
   logic [CNT_W-1:0]     r_frame_cnt;
   mode_e                r_mode;
   logic [AMP_W-1:0]     r_amp;
   logic [PHASE_W-1:0]   r_inc;
   logic [PHASE_W-1:0]   r_phase;
   logic [NUM_W-1:0]     r_num;
   logic [NUM_W-1:0]     r_sent;
   logic [FL_W-1:0]      r_flush_cnt;
   logic                 r_stop_pend;
   logic                 r_ready;
   logic [WIDTH-1:0]     r_sig;
   logic                 r_done;

   logic                 w_idle;
   logic                 w_frame_end;
   logic                 w_burst_end;
   mode_e                w_sel_mode;
   logic [AMP_W-1:0]     w_sel_amp;
   logic [PHASE_W-1:0]   w_next_phase;
   logic [WIDTH-1:0]     w_amp_ext;
   logic [WIDTH-1:0]     w_sine_val;
   logic [WIDTH-1:0]     w_next_sample;

   // In IDLE the upcoming sample is sample 0, built from the live inputs being latched
   assign w_idle       = (r_state == ST_IDLE);
   assign w_frame_end  = (r_frame_cnt == LAST_CNT);
   assign w_sel_mode   = w_idle ? mode_e'(mode) : r_mode;
   assign w_sel_amp    = w_idle ? amplitude : r_amp;
   assign w_next_phase = w_idle ? '0 : (r_phase + r_inc);
   assign w_amp_ext    = WIDTH'(w_sel_amp);

   // Burst ends on sample count reached (non-continuous) or a pending/coincident stop
   assign w_burst_end  = ((r_num != '0) && (r_sent == r_num)) || r_stop_pend || stop;

`ifdef FIR_STIM_SINE_EN
   logic [14:0] w_lut_mag;
   logic        w_lut_neg;
   logic [14:0] w_sine_mag;

   sine_lut_q15 u_sine_lut (
      .i_quadrant (w_next_phase[PHASE_W-1 -: 2]),
      .i_index    (w_next_phase[PHASE_W-3 -: 6]),
      .o_mag      (w_lut_mag),
      .o_neg      (w_lut_neg)
   );

   // Scale by amplitude, drop the Q15 fraction, then apply the quadrant sign
   assign w_sine_mag = 15'(({15'd0, w_sel_amp} * {15'd0, w_lut_mag}) >> 15);
   assign w_sine_val = w_lut_neg ? (-WIDTH'(w_sine_mag)) : WIDTH'(w_sine_mag);
`else
   assign w_sine_val = '0;
`endif

   // Waveform select for the sample that loads at the next frame wrap (or at start)
   always_comb begin
      w_next_sample = '0;
      case (w_sel_mode)
         MODE_IMPULSE: w_next_sample = w_idle ? w_amp_ext : '0;
         MODE_STEP:    w_next_sample = w_amp_ext;
         MODE_SQUARE:  w_next_sample = w_next_phase[PHASE_W-1] ? (-w_amp_ext) : w_amp_ext;
         MODE_SINE:    w_next_sample = w_sine_val;
         default:      w_next_sample = '0;
      endcase
   end

   // Control FSM with registered ready/sample/done outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_frame_cnt <= '0;
         r_mode      <= MODE_IMPULSE;
         r_amp       <= '0;
         r_inc       <= '0;
         r_phase     <= '0;
         r_num       <= '0;
         r_sent      <= '0;
         r_flush_cnt <= '0;
         r_stop_pend <= 1'b0;
         r_ready     <= 1'b0;
         r_sig       <= '0;
         r_done      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state     <= ST_RUN;
                  r_ready     <= 1'b1;
                  r_frame_cnt <= '0;
                  r_mode      <= mode_e'(mode);
                  r_amp       <= amplitude;
                  r_inc       <= phase_inc;
                  r_num       <= num_samples;
                  r_phase     <= '0;
                  r_sent      <= NUM_W'(1);
                  r_stop_pend <= 1'b0;
                  r_sig       <= w_next_sample;
               end
            end

            ST_RUN: begin
               r_frame_cnt <= w_frame_end ? '0 : (r_frame_cnt + 1'b1);
               if (stop) begin
                  r_stop_pend <= 1'b1;
               end
               if (w_frame_end) begin
                  if (w_burst_end) begin
                     r_stop_pend <= 1'b0;
                     r_sig       <= '0;
                     if (FLUSH_LEN == 0) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= FL_W'(1);
                     end
                  end else begin
                     r_sig   <= w_next_sample;
                     r_phase <= w_next_phase;
                     r_sent  <= r_sent + 1'b1;
                  end
               end
            end

            ST_FLUSH: begin
               r_frame_cnt <= w_frame_end ? '0 : (r_frame_cnt + 1'b1);
               if (w_frame_end) begin
                  if (r_flush_cnt == FL_W'(FLUSH_LEN)) begin
                     r_state <= ST_IDLE;
                     r_ready <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_flush_cnt <= r_flush_cnt + 1'b1;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign ready      = r_ready;
   assign sig_out    = r_sig;
   assign sample_stb = r_ready && (r_frame_cnt == '0);
   assign busy       = (r_state != ST_IDLE);
   assign done       = r_done;

endmodule

// File: tb/tb_fir_stim_source.sv
// tb_fir_stim_source: directed bench for fir_stim_source. Two instances share
// the stimulus: u_dut0 with FLUSH_LEN=0 and u_dut2 with FLUSH_LEN=2.
// Sine expectations follow FIR_STIM_SINE_EN as compiled.
module tb_fir_stim_source;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic [1:0]         mode = 2'd0;
   logic [14:0]        amplitude = '0;
   logic [15:0]        phase_inc = '0;
   logic [15:0]        num_samples = '0;

   logic               ready0, stb0, busy0, done0;
   logic signed [15:0] sig0;
   logic               ready2, stb2, busy2, done2;
   logic signed [15:0] sig2;

   logic               sel_f2 = 1'b0;
   logic               m_ready, m_stb, m_busy, m_done;
   logic signed [15:0] m_sig;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fir_stim_source #(.FLUSH_LEN(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
      .amplitude(amplitude), .phase_inc(phase_inc), .num_samples(num_samples),
      .ready(ready0), .sig_out(sig0), .sample_stb(stb0), .busy(busy0), .done(done0)
   );

   fir_stim_source #(.FLUSH_LEN(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
      .amplitude(amplitude), .phase_inc(phase_inc), .num_samples(num_samples),
      .ready(ready2), .sig_out(sig2), .sample_stb(stb2), .busy(busy2), .done(done2)
   );

   assign m_ready = sel_f2 ? ready2 : ready0;
   assign m_stb   = sel_f2 ? stb2   : stb0;
   assign m_busy  = sel_f2 ? busy2  : busy0;
   assign m_done  = sel_f2 ? done2  : done0;
   assign m_sig   = sel_f2 ? sig2   : sig0;

   // Pulse start for one cycle; returns at the falling edge inside cycle 0
   task automatic start_burst(input logic [1:0] m, input logic [14:0] a,
                              input logic [15:0] inc, input logic [15:0] n);
      @(negedge clk);
      mode = m; amplitude = a; phase_inc = inc; num_samples = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int cyc = 0;
      while ((busy0 || busy2) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (busy0 || busy2) begin
         errors++;
         $display("FAIL %s idle_timeout: busy0=%0b busy2=%0b expected 0", name, busy0, busy2);
      end
   endtask

   // Run one burst and check captures, hold, ready fall cycle and done pulse
   task automatic run_burst(input string name, input bit f2, input logic [1:0] m,
                            input logic [14:0] a, input logic [15:0] inc,
                            input logic [15:0] n, input int exp_n,
                            input logic signed [15:0] exp_v [8], input int exp_fall);
      int idx  = 0;
      int fall = -1;
      sel_f2 = f2;
      start_burst(m, a, inc, n);
      checks++;
      if (m_ready !== 1'b1 || m_busy !== 1'b1) begin
         errors++;
         $display("FAIL %s cycle0: ready=%0b busy=%0b expected 1 1", name, m_ready, m_busy);
      end
      for (int cyc = 0; cyc <= exp_fall + 64; cyc++) begin
         if (m_ready !== 1'b1) begin
            fall = cyc;
            break;
         end
         if (m_stb === 1'b1) begin
            checks++;
            if (idx >= exp_n) begin
               errors++;
               $display("FAIL %s extra_capture: capture %0d at cycle %0d, expected %0d captures", name, idx, cyc, exp_n);
            end else if (cyc != idx * 128 || m_sig !== exp_v[idx]) begin
               errors++;
               $display("FAIL %s capture%0d: cycle=%0d sig_out=%0d expected cycle=%0d sig_out=%0d",
                        name, idx, cyc, m_sig, idx * 128, exp_v[idx]);
            end
            idx++;
         end else if (cyc % 128 == 64 && idx > 0 && idx <= exp_n) begin
            checks++;
            if (m_sig !== exp_v[idx-1]) begin
               errors++;
               $display("FAIL %s hold%0d: sig_out=%0d expected %0d", name, idx - 1, m_sig, exp_v[idx-1]);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (fall != exp_fall) begin
         errors++;
         $display("FAIL %s ready_fall: cycle=%0d expected %0d (-1 = never)", name, fall, exp_fall);
      end
      checks++;
      if (idx != exp_n) begin
         errors++;
         $display("FAIL %s capture_count: got %0d expected %0d", name, idx, exp_n);
      end
      if (fall >= 0) begin
         checks++;
         if (m_done !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%0b busy=%0b expected 1 0", name, m_done, m_busy);
         end
         @(negedge clk);
         checks++;
         if (m_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: done=%0b expected 0", name, m_done);
         end
      end
      wait_idle(name);
   endtask

   task automatic test_reset;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({ready0, busy0, stb0, done0, ready2, busy2} !== 6'b0 || sig0 !== 16'sd0) begin
         errors++;
         $display("FAIL reset_state: ready=%0b busy=%0b stb=%0b done=%0b sig=%0d expected all 0",
                  ready0, busy0, stb0, done0, sig0);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({ready0, busy0, done0, ready2, busy2} !== 5'b0) begin
         errors++;
         $display("FAIL reset_release: ready=%0b busy=%0b done=%0b expected 0", ready0, busy0, done0);
      end
   endtask

   task automatic test_impulse;
      logic signed [15:0] ev [8];
      ev = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
      run_burst("impulse", 1'b0, 2'd0, 15'd1000, 16'h0000, 16'd4, 4, ev, 512);
   endtask

   task automatic test_step_flush;
      logic signed [15:0] ev [8];
      ev = '{16'sd4096, 16'sd4096, 16'sd4096, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
      run_burst("step_flush", 1'b1, 2'd1, 15'd4096, 16'h0000, 16'd3, 5, ev, 640);
   endtask

   task automatic test_square;
      logic signed [15:0] ev [8];
      ev = '{16'sd100, 16'sd100, -16'sd100, -16'sd100, 16'sd100, 16'sd100, 16'sd0, 16'sd0};
      run_burst("square", 1'b0, 2'd3, 15'd100, 16'h4000, 16'd6, 6, ev, 768);
   endtask

   task automatic test_sine;
      logic signed [15:0] ev [8];
`ifdef FIR_STIM_SINE_EN
      ev = '{16'sd0, 16'sd32766, 16'sd0, -16'sd32766, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
`else
      ev = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
`endif
      run_burst("sine_full", 1'b0, 2'd2, 15'd32767, 16'h4000, 16'd4, 4, ev, 512);
`ifdef FIR_STIM_SINE_EN
      ev = '{16'sd0, 16'sd923, -16'sd707, -16'sd382, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
`else
      ev = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
`endif
      run_burst("sine_fold", 1'b0, 2'd2, 15'd1000, 16'h5000, 16'd4, 4, ev, 512);
   endtask

   // Continuous run, start retrigger at 100 ignored, stop at 200 ends at 256
   task automatic test_stop;
      int fall0 = -1;
      int fall2 = -1;
      int stb_cnt = 0;
      sel_f2 = 1'b0;
      start_burst(2'd1, 15'd500, 16'h0000, 16'd0);
      for (int cyc = 0; cyc <= 600; cyc++) begin
         if (stb0 === 1'b1 && fall0 < 0) begin
            stb_cnt++;
            checks++;
            if (cyc != (stb_cnt - 1) * 128) begin
               errors++;
               $display("FAIL stop stb_cycle: cycle=%0d expected %0d", cyc, (stb_cnt - 1) * 128);
            end
         end
         if (cyc == 200) begin
            checks++;
            if (sig0 !== 16'sd500) begin
               errors++;
               $display("FAIL stop relatch: sig_out=%0d expected 500", sig0);
            end
         end
         if (cyc == 255) begin
            checks++;
            if (ready0 !== 1'b1) begin
               errors++;
               $display("FAIL stop ready_255: ready=%0b expected 1", ready0);
            end
         end
         if (fall0 < 0 && ready0 !== 1'b1) begin
            fall0 = cyc;
            checks++;
            if (done0 !== 1'b1) begin
               errors++;
               $display("FAIL stop done: done=%0b expected 1", done0);
            end
         end
         if (fall2 < 0 && ready2 !== 1'b1) fall2 = cyc;
         start = (cyc == 100);
         if (cyc == 100) begin
            mode = 2'd0; amplitude = 15'd9; num_samples = 16'd1;
         end
         stop = (cyc == 200);
         @(negedge clk);
      end
      checks++;
      if (fall0 != 256) begin
         errors++;
         $display("FAIL stop ready_fall: cycle=%0d expected 256", fall0);
      end
      checks++;
      if (stb_cnt != 2) begin
         errors++;
         $display("FAIL stop stb_count: got %0d expected 2", stb_cnt);
      end
      checks++;
      if (fall2 != 512) begin
         errors++;
         $display("FAIL stop flush_fall: cycle=%0d expected 512", fall2);
      end
      wait_idle("stop");
   endtask

   // start in the done cycle is accepted and loads a fresh sample 0
   task automatic test_back_to_back;
      int cyc = 0;
      sel_f2 = 1'b0;
      start_burst(2'd1, 15'd5, 16'h0000, 16'd1);
      while (done0 !== 1'b1 && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != 128) begin
         errors++;
         $display("FAIL b2b first_done: cycle=%0d expected 128", cyc);
      end
      amplitude = 15'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (ready0 !== 1'b1 || stb0 !== 1'b1 || sig0 !== 16'sd6 || done0 !== 1'b0) begin
         errors++;
         $display("FAIL b2b restart: ready=%0b stb=%0b sig=%0d done=%0b expected 1 1 6 0",
                  ready0, stb0, sig0, done0);
      end
      wait_idle("b2b");
   endtask

   // Asynchronous reset while running clears outputs without a clock edge
   task automatic test_reset_run;
      sel_f2 = 1'b0;
      start_burst(2'd1, 15'd777, 16'h0000, 16'd0);
      repeat (50) @(negedge clk);
      checks++;
      if (ready0 !== 1'b1 || sig0 !== 16'sd777) begin
         errors++;
         $display("FAIL reset_run pre: ready=%0b sig=%0d expected 1 777", ready0, sig0);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ready0, busy0, stb0, done0, busy2} !== 5'b0 || sig0 !== 16'sd0) begin
         errors++;
         $display("FAIL reset_run: ready=%0b busy=%0b stb=%0b done=%0b sig=%0d expected all 0",
                  ready0, busy0, stb0, done0, sig0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_step_flush();
      test_square();
      test_sine();
      test_stop();
      test_back_to_back();
      test_reset_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
